// File: rtl/dma_responder_if.sv
// dma_responder_if: read/write request bus between a DMA initiator and the
// dma_responder memory target.
//   Read  : i_rd_en/i_rd_addr request, o_rd_ready accept, o_rd_valid/o_rd_data return
//   Write : i_wr_en/i_wr_addr/i_wr_data request, o_wr_ready accept
// The master modport is the initiator side, the slave modport the responder side.
interface dma_responder_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              i_rd_en;
  logic [ADDR_W-1:0] i_rd_addr;
  logic              o_rd_ready;
  logic              o_rd_valid;
  logic [DATA_W-1:0] o_rd_data;
  logic              i_wr_en;
  logic [ADDR_W-1:0] i_wr_addr;
  logic [DATA_W-1:0] i_wr_data;
  logic              o_wr_ready;

  modport master (
    output i_rd_en, i_rd_addr, i_wr_en, i_wr_addr, i_wr_data,
    input  o_rd_ready, o_rd_valid, o_rd_data, o_wr_ready
  );

  modport slave (
    input  i_rd_en, i_rd_addr, i_wr_en, i_wr_addr, i_wr_data,
    output o_rd_ready, o_rd_valid, o_rd_data, o_wr_ready
  );
endinterface

// File: rtl/dma_responder.sv
// dma_responder: single-port byte memory serving a DMA initiator.
// Reads are queued (address only, in order) and popped onto the array whenever
// no write claims it; popped reads return RD_LAT cycles after the pop edge.
// A starvation guard drops o_wr_ready for one cycle after four consecutive
// write-won cycles with reads waiting, forcing a pop.
// Ports:
//   i_clk  : clock, all state on rising edge
//   i_rst  : asynchronous active-low reset
//   bus    : dma_responder_if slave modport (read/write request + read return)
// RD_LAT legal range is 1..4.
module dma_responder #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2,
  parameter int QDEPTH = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  dma_responder_if.slave bus
);
  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST     = PTR_W'(QDEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ZERO     = PTR_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE      = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(QDEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [2:0]       STARVE_LIMIT = 3'd4;

  logic [DATA_W-1:0] mem_r  [2**ADDR_W];
  logic [ADDR_W-1:0] fifo_r [QDEPTH];
  logic [PTR_W-1:0]  wptr_r, rptr_r;
  logic [CNT_W-1:0]  count_r, count_s;
  logic [2:0]        starve_r, starve_s;
  logic              rd_ready_r, wr_ready_r;
  logic [RD_LAT:0]   vld_r;
  logic [DATA_W-1:0] dat_r  [RD_LAT+1];
  logic              wr_acc_s, rd_acc_s, pop_s;
  logic [DATA_W-1:0] rd_word_s;

  // Arbitration, queue occupancy and starvation-counter next state.
  always_comb begin
    wr_acc_s  = bus.i_wr_en & wr_ready_r;
    rd_acc_s  = bus.i_rd_en & rd_ready_r;
    // An accepted write owns the array; otherwise a waiting read pops.
    pop_s     = ~wr_acc_s & (count_r != CNT_ZERO);
    rd_word_s = mem_r[fifo_r[rptr_r]];
    count_s   = count_r;
    starve_s  = starve_r;
    if (rd_acc_s && !pop_s) begin
      count_s = count_r + CNT_ONE;
    end else if (!rd_acc_s && pop_s) begin
      count_s = count_r - CNT_ONE;
    end else begin
      count_s = count_r;
    end
    if (pop_s || (starve_r == STARVE_LIMIT)) begin
      starve_s = 3'd0;
    end else if (wr_acc_s && (count_r != CNT_ZERO)) begin
      starve_s = starve_r + 3'd1;
    end else begin
      starve_s = starve_r;
    end
  end

  // Queue pointers, occupancy, starvation counter and registered ready flags.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wptr_r     <= PTR_ZERO;
      rptr_r     <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      starve_r   <= 3'd0;
      rd_ready_r <= 1'b1;
      wr_ready_r <= 1'b1;
    end else begin
      count_r  <= count_s;
      starve_r <= starve_s;
      // Ready flags look at next-cycle state so they stay purely registered.
      rd_ready_r <= (count_s < CNT_FULL);
      wr_ready_r <= (starve_s != STARVE_LIMIT);
      if (rd_acc_s) begin
        wptr_r <= (wptr_r == PTR_LAST) ? PTR_ZERO : wptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rptr_r <= (rptr_r == PTR_LAST) ? PTR_ZERO : rptr_r + PTR_ONE;
      end
    end
  end

  // Read-address queue storage; validity is tracked by pointers/occupancy.
  always_ff @(posedge i_clk) begin
    if (rd_acc_s) begin
      fifo_r[wptr_r] <= bus.i_rd_addr;
    end
  end

  // Memory array write port; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (wr_acc_s) begin
      mem_r[bus.i_wr_addr] <= bus.i_wr_data;
    end
  end

  // Read return pipeline: array read at the pop edge, then RD_LAT-1 more
  // stages plus the output register. Data is zeroed whenever not valid.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      vld_r <= '0;
      for (int i = 0; i <= RD_LAT; i++) begin
        dat_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      vld_r    <= {vld_r[RD_LAT-1:0], pop_s};
      dat_r[0] <= pop_s ? rd_word_s : {DATA_W{1'b0}};
      for (int i = 1; i <= RD_LAT; i++) begin
        dat_r[i] <= dat_r[i-1];
      end
    end
  end

  assign bus.o_rd_ready = rd_ready_r;
  assign bus.o_wr_ready = wr_ready_r;
  assign bus.o_rd_valid = vld_r[RD_LAT];
  assign bus.o_rd_data  = dat_r[RD_LAT];
endmodule

// File: tb/tb_dma_responder.sv
// tb_dma_responder: scoreboard bench for dma_responder (RD_LAT=2, QDEPTH=4).
// Expected read data is taken from a shadow memory when a read is accepted and
// queued; a negedge monitor pops and compares on every o_rd_valid.
module tb_dma_responder;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 2;
  localparam int QDEPTH = 4;

  logic clk = 1'b0;
  logic rst;

  dma_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dma_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .QDEPTH(QDEPTH)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [DATA_W-1:0] sb [$];
  logic [DATA_W-1:0] shadow [2**ADDR_W];
  bit last_wacc, last_racc;
  bit mon_en    = 1'b0;
  bit wr_stream = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // One clock: decide acceptance from the registered ready flags, update the
  // shadow memory (write first, so a same-edge read sees it), queue expectations.
  task automatic step();
    bit wacc, racc;
    wacc = bus.i_wr_en && bus.o_wr_ready;
    racc = bus.i_rd_en && bus.o_rd_ready;
    @(posedge clk);
    if (wacc) shadow[bus.i_wr_addr] = bus.i_wr_data;
    if (racc) sb.push_back(shadow[bus.i_rd_addr]);
    last_wacc = wacc;
    last_racc = racc;
    #1;
    if (wr_stream && wacc) begin
      bus.i_wr_addr = bus.i_wr_addr + 10'd1;
      bus.i_wr_data = bus.i_wr_data + 8'd1;
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (bus.o_rd_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (bus.o_rd_valid !== 1'b1) check("valid_timeout", {31'd0, bus.o_rd_valid}, 32'd1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 50) begin
      step();
      k++;
    end
    repeat (4) step();
    check("drain_empty", sb.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_ready"}, {31'd0, bus.o_rd_ready}, 32'd1);
    check({tag, "_wr_ready"}, {31'd0, bus.o_wr_ready}, 32'd1);
    check({tag, "_rd_valid"}, {31'd0, bus.o_rd_valid}, 32'd0);
    check({tag, "_rd_data"},  {24'd0, bus.o_rd_data},  32'd0);
  endtask

  // Return monitor: every valid must match the oldest expectation; idle data is zero.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.o_rd_valid === 1'b1) begin
        if (sb.size() == 0) check("unexpected_valid", {31'd0, bus.o_rd_valid}, 32'd0);
        else check("rd_data", {24'd0, bus.o_rd_data}, {24'd0, sb.pop_front()});
      end else begin
        check("idle_data_zero", {24'd0, bus.o_rd_data}, 32'd0);
      end
    end
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected to finish earlier");
    $fatal(1);
  end

  initial begin
    int n;
    int rd_idx;
    int cyc;
    bus.i_rd_en = 1'b0; bus.i_rd_addr = 10'd0;
    bus.i_wr_en = 1'b0; bus.i_wr_addr = 10'd0; bus.i_wr_data = 8'd0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    mon_en = 1'b1;

    // Write 0xA5 @5 on the first edge after release, idle, then read @5.
    bus.i_wr_en = 1'b1; bus.i_wr_addr = 10'd5; bus.i_wr_data = 8'hA5;
    step();
    check("first_edge_wr_acc", {31'd0, last_wacc}, 32'd1);
    bus.i_wr_en = 1'b0;
    step();
    bus.i_rd_en = 1'b1; bus.i_rd_addr = 10'd5;
    step();
    check("rd5_acc", {31'd0, last_racc}, 32'd1);
    bus.i_rd_en = 1'b0;
    wait_valid(n);
    check("unloaded_latency", n, 32'd3);
    step();
    check("single_pulse", {31'd0, bus.o_rd_valid}, 32'd0);
    drain();

    // Same-edge write 0x3C @7 and read @7.
    bus.i_wr_en = 1'b1; bus.i_wr_addr = 10'd7; bus.i_wr_data = 8'h3C;
    bus.i_rd_en = 1'b1; bus.i_rd_addr = 10'd7;
    step();
    check("same_edge_acc", {30'd0, last_wacc, last_racc}, 32'd3);
    bus.i_wr_en = 1'b0; bus.i_rd_en = 1'b0;
    drain();

    // Preload @0..@5, then 6 back-to-back reads under continuous writes.
    for (int i = 0; i < 6; i++) begin
      bus.i_wr_en = 1'b1; bus.i_wr_addr = 10'(i); bus.i_wr_data = 8'(8'h10 + i);
      step();
    end
    bus.i_wr_en = 1'b0;
    step();
    wr_stream = 1'b1;
    bus.i_wr_en = 1'b1; bus.i_wr_addr = 10'h200; bus.i_wr_data = 8'h80;
    rd_idx = 0; cyc = 0;
    bus.i_rd_en = 1'b1; bus.i_rd_addr = 10'd0;
    while (rd_idx < 6 && cyc < 100) begin
      step();
      cyc++;
      if (last_racc) begin
        rd_idx++;
        if (rd_idx == 4) check("rd_ready_low_when_full", {31'd0, bus.o_rd_ready}, 32'd0);
      end
      bus.i_rd_addr = 10'(rd_idx);
    end
    check("all_reads_accepted", rd_idx, 32'd6);
    bus.i_rd_en = 1'b0;
    bus.i_wr_en = 1'b0; wr_stream = 1'b0;
    drain();

    // One pending read under continuous writes: starvation guard forces a pop.
    wr_stream = 1'b1;
    bus.i_wr_en = 1'b1; bus.i_wr_addr = 10'h300; bus.i_wr_data = 8'hC0;
    bus.i_rd_en = 1'b1; bus.i_rd_addr = 10'd5;
    step();
    check("starve_rd_acc", {31'd0, last_racc}, 32'd1);
    bus.i_rd_en = 1'b0;
    n = 0;
    while (bus.o_wr_ready === 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("write_won_cycles", n, 32'd4);
    step();
    check("forced_pop_no_write", {31'd0, last_wacc}, 32'd0);
    check("wr_ready_back_high", {31'd0, bus.o_wr_ready}, 32'd1);
    wait_valid(n);
    check("forced_pop_latency", n, 32'd2);
    bus.i_wr_en = 1'b0; wr_stream = 1'b0;
    drain();

    // Reset with three reads queued behind continuous writes.
    wr_stream = 1'b1;
    bus.i_wr_en = 1'b1; bus.i_wr_addr = 10'h380; bus.i_wr_data = 8'hE0;
    for (int i = 0; i < 3; i++) begin
      bus.i_rd_en = 1'b1; bus.i_rd_addr = 10'(i);
      step();
      check("queue_rd_acc", {31'd0, last_racc}, 32'd1);
    end
    bus.i_rd_en = 1'b0;
    #2 rst = 1'b0;
    sb.delete();
    #1 check_reset_outputs("midrun_reset");
    bus.i_wr_en = 1'b0; wr_stream = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (8) step();
    check("post_reset_rd_ready", {31'd0, bus.o_rd_ready}, 32'd1);
    bus.i_rd_en = 1'b1; bus.i_rd_addr = 10'd5;
    step();
    bus.i_rd_addr = 10'd0;
    step();
    check("post_reset_rd_acc", {31'd0, last_racc}, 32'd1);
    bus.i_rd_en = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dma_responder.md
DMA_RESPONDER -- requirements
Module: dma_responder

Interface
REQ-001 Parameter ADDR_W, default 10, DMA address width (memory depth 2^ADDR_W bytes).
REQ-002 Parameter DATA_W, default 8, data width.
REQ-003 Parameter RD_LAT, default 2, read pipeline stages; legal range 1..4.
REQ-004 Parameter QDEPTH, default 4, read-request queue depth.
REQ-005 i_clk  input  1  single clock; all state on rising edge.
REQ-006 i_rst  input  1  asynchronous, active-low reset.
REQ-007 i_rd_en  input  1  read request from DMA initiator.
REQ-008 i_rd_addr  input  ADDR_W  read byte address.
REQ-009 o_rd_ready  output  1  request queue can accept; read accepted when i_rd_en && o_rd_ready.
REQ-010 o_rd_valid  output  1  one-cycle pulse per returned read datum.
REQ-011 o_rd_data  output  DATA_W  read data, qualified by o_rd_valid.
REQ-012 i_wr_en  input  1  write request.
REQ-013 i_wr_addr  input  ADDR_W  write byte address.
REQ-014 i_wr_data  input  DATA_W  write data.
REQ-015 o_wr_ready  output  1  write accepted when i_wr_en && o_wr_ready.

Function
REQ-016 Storage: single-port array of 2^ADDR_W x DATA_W; one access (write or read dequeue) per cycle.
REQ-017 Accepted reads are pushed to an in-order FIFO of QDEPTH entries holding address only.
REQ-018 o_rd_ready is high iff queue occupancy < QDEPTH, derived from registered occupancy; no combinational path from i_rd_en.
REQ-019 Arbitration per cycle: accepted write wins the array; otherwise a non-empty queue pops its head and reads the array.
REQ-020 Starvation guard: a 3-bit counter increments each cycle a write is accepted while the queue is non-empty, clears on any pop; when it reaches 4, o_wr_ready is low for the next cycle, forcing a pop, then the counter clears.
REQ-021 o_wr_ready is high at all other times.
REQ-022 Popped read enters an RD_LAT-stage pipeline; o_rd_valid/o_rd_data appear RD_LAT cycles after the pop edge.
REQ-023 Unloaded latency: read accepted at edge N, queue empty, no write -> pop at edge N+1, o_rd_valid high in the cycle after edge N+1+RD_LAT.
REQ-024 Data returned in acceptance order; no drop, no duplication.
REQ-025 Read-after-write: write accepted at or before the edge a read pops returns the new data; write and read accepted on the same edge to the same address -> read returns the new data (write wins the array first).
REQ-026 Queue full with simultaneous pop: o_rd_ready stays low that cycle; it rises the following cycle.
REQ-027 Simultaneous push and pop leaves occupancy unchanged.
REQ-028 o_rd_data is 0 whenever o_rd_valid is low.
REQ-029 i_rd_en while o_rd_ready low is ignored; initiator holds request until accepted.

Reset
REQ-030 i_rst low asynchronously clears queue, pointers, occupancy, pipeline valids, and starvation counter.
REQ-031 Reset values: o_rd_ready=1, o_wr_ready=1, o_rd_valid=0, o_rd_data=0.
REQ-032 Array contents are not reset; in-flight reads at reset are discarded, never returned.
REQ-033 First request is accepted on the first rising edge after i_rst goes high.

Verification (RD_LAT=2, QDEPTH=4)
REQ-034 Write 0xA5 @5, idle, read @5 accepted edge N -> o_rd_valid with 0xA5 after edge N+3, single-cycle pulse.
REQ-035 Same-edge write 0x3C @7 and read @7 -> returned data 0x3C.
REQ-036 Continuous writes + 6 back-to-back reads of @0..@5 -> o_rd_ready low after 4 accepted; all 6 eventually return in order with correct data.
REQ-037 Continuous writes, one read pending -> after 4 write-won cycles o_wr_ready low one cycle, read pops, valid 2 cycles later.
REQ-038 Assert i_rst with 3 reads queued -> outputs at reset values immediately; no o_rd_valid after release; prior array data still readable.
